shift_frame_ctrl: RTL and testbench

//   Sequencer for the free-running serial shift path. It accepts a parallel word

---
 rtl/shift_frame_ctrl_if.sv | 26 ++
 rtl/shift_frame_ctrl.sv | 99 +++++++++
 tb/tb_shift_frame_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_frame_ctrl_if.sv
// Word-in / bit-out port bundle for shift_frame_ctrl.
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready; in_data must be
// stable while in_valid is high, and in_ready depends only on controller state (never on in_valid).
interface shift_frame_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             en;
    logic             s_out;
    logic             s_valid;
    logic             frame_start;
    logic             frame_done;
    logic             busy;

    modport master (
        output in_valid, in_data, en,
        input  in_ready, s_out, s_valid, frame_start, frame_done, busy
    );

    modport slave (
        input  in_valid, in_data, en,
        output in_ready, s_out, s_valid, frame_start, frame_done, busy
    );
endinterface

// File: rtl/shift_frame_ctrl.sv
// Serialises one parallel word per valid/ready handshake onto a single-bit stream,
// framing it with start/done pulses and a fixed idle gap before the next word is accepted.
module shift_frame_ctrl #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    shift_frame_ctrl_if.slave   bus,
    output logic [1:0]          dbg_state
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             done_q, done_d;
    logic             take;

    assign take = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    shreg_d = bus.in_data;
                    cnt_d   = CNT_LAST;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // en low freezes everything, so the presented bit simply stretches
                if (bus.en) begin
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        gap_d   = GAP_LOAD;
                        state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
                    end else begin
                        shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg_q[WIDTH-1:1]};
                        cnt_d   = cnt_q - 1'b1;
                    end
                end
            end
            ST_GAP: begin
                // the gap runs on clk alone; the frame_done cycle is its first cycle
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready    = (state_q == ST_IDLE) && !reset;
        bus.s_valid     = (state_q == ST_SHIFT);
        bus.s_out       = (state_q == ST_SHIFT) &&
                          (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
        bus.frame_start = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
        bus.frame_done  = done_q;
        bus.busy        = (state_q != ST_IDLE);
        dbg_state       = state_q;
    end
endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Directed bench: three controller instances (GAP=2 MSB-first, GAP=0 MSB-first, GAP=2 LSB-first).
module tb_shift_frame_ctrl;
    logic clk;
    logic reset;

    logic       drv_valid [3];
    logic [7:0] drv_data  [3];
    logic       drv_en    [3];
    logic       mon_ready [3];
    logic       mon_sv    [3];
    logic       mon_so    [3];
    logic       mon_start [3];
    logic       mon_done  [3];
    logic       mon_busy  [3];
    logic [1:0] mon_state [3];

    int total;
    int bad;

    shift_frame_ctrl_if #(.WIDTH(8)) if0 ();
    shift_frame_ctrl_if #(.WIDTH(8)) if1 ();
    shift_frame_ctrl_if #(.WIDTH(8)) if2 ();

    shift_frame_ctrl #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave), .dbg_state(mon_state[0]));
    shift_frame_ctrl #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave), .dbg_state(mon_state[1]));
    shift_frame_ctrl #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b0)) dut2 (
        .clk(clk), .reset(reset), .bus(if2.slave), .dbg_state(mon_state[2]));

    assign if0.in_valid = drv_valid[0];
    assign if0.in_data  = drv_data[0];
    assign if0.en       = drv_en[0];
    assign if1.in_valid = drv_valid[1];
    assign if1.in_data  = drv_data[1];
    assign if1.en       = drv_en[1];
    assign if2.in_valid = drv_valid[2];
    assign if2.in_data  = drv_data[2];
    assign if2.en       = drv_en[2];

    assign mon_ready[0] = if0.in_ready;
    assign mon_sv[0]    = if0.s_valid;
    assign mon_so[0]    = if0.s_out;
    assign mon_start[0] = if0.frame_start;
    assign mon_done[0]  = if0.frame_done;
    assign mon_busy[0]  = if0.busy;
    assign mon_ready[1] = if1.in_ready;
    assign mon_sv[1]    = if1.s_valid;
    assign mon_so[1]    = if1.s_out;
    assign mon_start[1] = if1.frame_start;
    assign mon_done[1]  = if1.frame_done;
    assign mon_busy[1]  = if1.busy;
    assign mon_ready[2] = if2.in_ready;
    assign mon_sv[2]    = if2.s_valid;
    assign mon_so[2]    = if2.s_out;
    assign mon_start[2] = if2.frame_start;
    assign mon_done[2]  = if2.frame_done;
    assign mon_busy[2]  = if2.busy;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // vector table
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       en;
        logic       r;
        logic       sv;
        logic       so;
        logic       st;
        logic       dn;
        logic       bz;
    } vec_t;

    vec_t tbl[$];
    logic exp_q[$];

    function automatic void add(input logic v, input logic [7:0] d, input logic en,
                                input logic r, input logic sv, input logic so,
                                input logic st, input logic dn, input logic bz);
        vec_t x;
        x.v = v; x.d = d; x.en = en;
        x.r = r; x.sv = sv; x.so = so; x.st = st; x.dn = dn; x.bz = bz;
        tbl.push_back(x);
    endfunction

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            drv_valid[0] = tbl[i].v;
            drv_data[0]  = tbl[i].d;
            drv_en[0]    = tbl[i].en;
            chk($sformatf("row%0d in_ready", i),    mon_ready[0], tbl[i].r);
            chk($sformatf("row%0d s_valid", i),     mon_sv[0],    tbl[i].sv);
            chk($sformatf("row%0d s_out", i),       mon_so[0],    tbl[i].so);
            chk($sformatf("row%0d frame_start", i), mon_start[0], tbl[i].st);
            chk($sformatf("row%0d frame_done", i),  mon_done[0],  tbl[i].dn);
            chk($sformatf("row%0d busy", i),        mon_busy[0],  tbl[i].bz);
            cyc();
        end
    endtask

    // Two words with in_valid held high; scoreboard the bit stream and the handshake spacing.
    task automatic stream2(input int k, input logic [7:0] w0, input logic [7:0] w1,
                           input logic msb, input int exp_gap, input int exp_done_ready);
        int hs, nbits, last_consume, hs2_cyc, seen_dr, ndone;
        logic [7:0] w;
        exp_q.delete();
        for (int j = 0; j < 2; j++) begin
            w = (j == 0) ? w0 : w1;
            for (int i = 0; i < 8; i++) exp_q.push_back(msb ? w[7-i] : w[i]);
        end
        hs = 0; nbits = 0; last_consume = -100; hs2_cyc = -1; seen_dr = 0; ndone = 0;
        drv_valid[k] = 1'b1;
        drv_data[k]  = w0;
        drv_en[k]    = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (mon_ready[k] && drv_valid[k]) begin
                hs++;
                if (hs == 2) hs2_cyc = c;
            end
            if (mon_sv[k]) begin
                if (exp_q.size() == 0) chk($sformatf("dut%0d extra_bit", k), 1, 0);
                else chk($sformatf("dut%0d bit%0d", k, nbits), mon_so[k], exp_q.pop_front());
                nbits++;
                if (nbits == 8) last_consume = c;
            end
            if (mon_done[k]) ndone++;
            if (mon_done[k] && mon_ready[k]) seen_dr = 1;
            cyc();
            if (hs == 1) drv_data[k] = w1;
            if (hs == 2) drv_valid[k] = 1'b0;
            if (nbits == 16) break;
        end
        for (int c = 0; c < 4; c++) begin
            if (mon_done[k]) ndone++;
            if (mon_done[k] && mon_ready[k]) seen_dr = 1;
            cyc();
        end
        chk($sformatf("dut%0d nbits", k), nbits, 16);
        chk($sformatf("dut%0d exp_q_left", k), exp_q.size(), 0);
        chk($sformatf("dut%0d hs_spacing", k), hs2_cyc - last_consume, exp_gap);
        chk($sformatf("dut%0d done_count", k), ndone, 2);
        chk($sformatf("dut%0d done_with_ready", k), seen_dr, exp_done_ready);
        chk($sformatf("dut%0d idle_ready", k), mon_ready[k], 1);
        drv_en[k] = 1'b0;
    endtask

    logic [7:0] wa;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drv_valid[k] = 1'b0;
            drv_data[k]  = 8'h00;
            drv_en[k]    = 1'b0;
        end

        // 0xA5 frame, straight through
        wa = 8'hA5;
        add(1, 8'hA5, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 8'h00, 1, 0, 1, wa[7-i], (i == 0), 0, 1);
        add(0, 8'h00, 1, 0, 0, 0, 0, 1, 1);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 1);
        // IDLE again: take 0x3C; then stall bit 3 and wiggle in_data during SHIFT and GAP
        add(1, 8'h3C, 1, 1, 0, 0, 0, 0, 0);
        add(1, 8'hFF, 1, 0, 1, 0, 1, 0, 1);
        add(1, 8'h00, 1, 0, 1, 0, 0, 0, 1);
        add(1, 8'hAA, 0, 0, 1, 1, 0, 0, 1);
        add(1, 8'h55, 0, 0, 1, 1, 0, 0, 1);
        add(1, 8'h0F, 0, 0, 1, 1, 0, 0, 1);
        add(1, 8'hF0, 1, 0, 1, 1, 0, 0, 1);
        add(1, 8'h12, 1, 0, 1, 1, 0, 0, 1);
        add(1, 8'h34, 1, 0, 1, 1, 0, 0, 1);
        add(1, 8'h56, 1, 0, 1, 1, 0, 0, 1);
        add(1, 8'h78, 1, 0, 1, 0, 0, 0, 1);
        add(1, 8'h9A, 1, 0, 1, 0, 0, 0, 1);
        add(1, 8'h5A, 1, 0, 0, 0, 0, 1, 1);
        add(1, 8'hC3, 1, 0, 0, 0, 0, 0, 1);
        add(0, 8'hE7, 1, 1, 0, 0, 0, 0, 0);
        add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0);

        cyc();
        cyc();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dut%0d rst in_ready", k), mon_ready[k], 0);
            chk($sformatf("dut%0d rst busy", k),     mon_busy[k],  0);
            chk($sformatf("dut%0d rst s_valid", k),  mon_sv[k],    0);
        end
        chk("rst s_out", mon_so[0], 0);
        chk("rst frame_start", mon_start[0], 0);
        chk("rst frame_done", mon_done[0], 0);
        chk("rst state", mon_state[0], 0);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("dut%0d post_rst in_ready", k), mon_ready[k], 1);

        run_table();

        stream2(0, 8'hFF, 8'h00, 1'b1, 3, 0);
        stream2(1, 8'hFF, 8'h00, 1'b1, 1, 1);
        stream2(2, 8'h01, 8'h80, 1'b0, 3, 0);

        // asynchronous reset while bit 4 of 0xFF is presented
        drv_valid[0] = 1'b1;
        drv_data[0]  = 8'hFF;
        drv_en[0]    = 1'b1;
        cyc();
        drv_valid[0] = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("pre_abort s_valid", mon_sv[0], 1);
        chk("pre_abort s_out", mon_so[0], 1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort s_valid", mon_sv[0], 0);
        chk("abort s_out", mon_so[0], 0);
        chk("abort busy", mon_busy[0], 0);
        chk("abort in_ready", mon_ready[0], 0);
        cyc();
        reset = 1'b0;
        #1;
        chk("after_abort in_ready", mon_ready[0], 1);
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("after_abort done c%0d", c), mon_done[0], 0);
            chk($sformatf("after_abort s_valid c%0d", c), mon_sv[0], 0);
            cyc();
        end
        stream2(0, 8'h81, 8'h81, 1'b1, 3, 0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
